// File: rtl/ahb_arbiter_slave_2.sv
// ---------------------------------------------------------------------------
// ahb_arbiter_slave_2
//   Per-slave round-robin arbiter for slave 2 of the AHB interconnect.
//   Grants address-phase ownership to one of CHANNEL_NUM masters. It drives
//   the one-hot payload-mux select and a data-phase owner vector for the
//   response return path.
//
// Ports
//   HCLK     in   system clock, rising edge
//   HRESETn  in   synchronous active-low reset
//   hreq     in   [CHANNEL_NUM] per-master request decoded to slave 2
//   hlast    in   [CHANNEL_NUM] current address beat is the final beat
//   hready   in   slave-2 HREADY
//   sel      out  [CHANNEL_NUM] registered one-hot address-phase grant
//   sel_dp   out  [CHANNEL_NUM] registered one-hot data-phase owner
//   busy     out  an owner is granted
//
// Optional feature
//   AHB_ARB_TIMEOUT_EN : when defined, the owner is forced to hand over
//   after MAX_HOLD accepted beats, but only if another master is requesting.
// ---------------------------------------------------------------------------
module ahb_arbiter_slave_2 #(
  parameter int CHANNEL_NUM = 2,
  parameter int MAX_HOLD    = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [CHANNEL_NUM-1:0] hreq,
  input  logic [CHANNEL_NUM-1:0] hlast,
  input  logic                   hready,
  output logic [CHANNEL_NUM-1:0] sel,
  output logic [CHANNEL_NUM-1:0] sel_dp,
  output logic                   busy
);

  localparam int PTR_W = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 2..255");
  end

  typedef enum logic {IDLE, OWN} state_t;

  state_t           state;
  logic [PTR_W-1:0] last;     // most recent winner; equals the owner in OWN

  // Round-robin search from ptr+1 upward with wrap. Returns {found, index}.
  // Iterating from lowest priority to highest lets the highest-priority
  // requester overwrite the result last.
  function automatic logic [PTR_W:0] rr_pick(input logic [CHANNEL_NUM-1:0] req,
                                             input logic [PTR_W-1:0]       ptr);
    logic [PTR_W:0] res;
    int             idx;
    res = '0;
    for (int i = CHANNEL_NUM; i >= 1; i--) begin
      idx = (int'(ptr) + i) % CHANNEL_NUM;
      if (req[idx]) res = {1'b1, PTR_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [CHANNEL_NUM-1:0] onehot(input logic [PTR_W-1:0] ptr);
    logic [CHANNEL_NUM-1:0] v;
    v      = '0;
    v[ptr] = 1'b1;
    return v;
  endfunction

  logic [PTR_W:0]   pick;
  logic             win_found;
  logic [PTR_W-1:0] win;
  logic             owner_req;
  logic             owner_last;
  logic             force_rel;
  logic             release_c;

  assign pick       = rr_pick(hreq, last);
  assign win_found  = pick[PTR_W];
  assign win        = pick[PTR_W-1:0];
  assign owner_req  = hreq[last];
  assign owner_last = hlast[last];

`ifdef AHB_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;
  logic       others_req;

  function automatic logic [7:0] sat_inc(input logic [7:0] cnt);
    return (cnt >= 8'(MAX_HOLD - 1)) ? 8'(MAX_HOLD - 1) : cnt + 8'd1;
  endfunction

  assign others_req = |(hreq & ~onehot(last));
  assign force_rel  = hready && owner_req && others_req &&
                      (hold_cnt == 8'(MAX_HOLD - 1));

  // Counts accepted owner beats; any release starts a fresh tenure.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      hold_cnt <= '0;
    end else if (state == IDLE || release_c) begin
      hold_cnt <= '0;
    end else if (hready && owner_req) begin
      hold_cnt <= sat_inc(hold_cnt);
    end
  end
`else
  assign force_rel = 1'b0;
`endif

  // Wait states never release; a dropped request or final beat does.
  assign release_c = hready && (!owner_req || owner_last || force_rel);

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state  <= IDLE;
      sel    <= '0;
      sel_dp <= '0;
      busy   <= 1'b0;
      last   <= PTR_W'(CHANNEL_NUM - 1);
    end else begin
      // sel is one-hot, so masking with hreq gates it by the owner's request.
      if (hready) sel_dp <= sel & hreq;

      case (state)
        IDLE: begin
          if (win_found) begin
            state <= OWN;
            sel   <= onehot(win);
            busy  <= 1'b1;
            last  <= win;
          end
        end
        OWN: begin
          if (release_c) begin
            if (win_found) begin
              sel  <= onehot(win);
              last <= win;
            end else begin
              state <= IDLE;
              sel   <= '0;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          sel   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_arbiter_slave_2.sv
// ---------------------------------------------------------------------------
// tb_ahb_arbiter_slave_2
//   Directed test-plan sequences followed by randomized traffic, all checked
//   against a transaction-level model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_ahb_arbiter_slave_2;

  localparam int CN = 2;
  localparam int MH = 4;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic [CN-1:0] hreq;
  logic [CN-1:0] hlast;
  logic          hready;
  logic [CN-1:0] sel;
  logic [CN-1:0] sel_dp;
  logic          busy;

  always #5 HCLK = ~HCLK;

  ahb_arbiter_slave_2 #(
    .CHANNEL_NUM (CN),
    .MAX_HOLD    (MH)
  ) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .hreq    (hreq),
    .hlast   (hlast),
    .hready  (hready),
    .sel     (sel),
    .sel_dp  (sel_dp),
    .busy    (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: owner index (-1 = none), pointer, data-phase owner, hold.
  int m_owner = -1;
  int m_last  = CN - 1;
  int m_dp    = -1;
  int m_hold  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CN-1:0] vec(input int idx);
    logic [CN-1:0] v;
    v = '0;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  function automatic int search(input logic [CN-1:0] rq, input int from);
    for (int k = 1; k <= CN; k++) begin
      if (rq[(from + k) % CN]) return (from + k) % CN;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rst_n, input logic [CN-1:0] rq,
                            input logic [CN-1:0] lt, input logic rdy);
    int            w;
    logic          rel;
    logic          accept;
    logic [CN-1:0] others;
    if (!rst_n) begin
      m_owner = -1;
      m_last  = CN - 1;
      m_dp    = -1;
      m_hold  = 0;
    end else begin
      if (rdy) m_dp = (m_owner >= 0 && rq[m_owner]) ? m_owner : -1;
      if (m_owner < 0) begin
        w = search(rq, m_last);
        if (w >= 0) begin
          m_owner = w;
          m_last  = w;
        end
        m_hold = 0;
      end else begin
        accept = rdy && rq[m_owner];
        rel    = rdy && (!rq[m_owner] || lt[m_owner]);
        others = rq;
        others[m_owner] = 1'b0;
`ifdef AHB_ARB_TIMEOUT_EN
        if (accept && m_hold == MH - 1 && others != '0) rel = 1'b1;
`endif
        if (rel) begin
          w       = search(rq, m_last);
          m_owner = w;
          if (w >= 0) m_last = w;
          m_hold  = 0;
        end else if (accept && m_hold < MH - 1) begin
          m_hold++;
        end
      end
    end
  endtask

  task automatic cycle(input logic rst_n, input logic [CN-1:0] rq,
                       input logic [CN-1:0] lt, input logic rdy);
    HRESETn = rst_n;
    hreq    = rq;
    hlast   = lt;
    hready  = rdy;
    model_step(rst_n, rq, lt, rdy);
    @(posedge HCLK);
    #1;
    check("sel", sel, vec(m_owner));
    check("sel_dp", sel_dp, vec(m_dp));
    check("busy", busy, m_owner >= 0);
    check("onehot", ($countones(sel) <= 1) && ($countones(sel_dp) <= 1), 1'b1);
  endtask

  initial begin
    HRESETn = 1'b0;
    hreq    = '0;
    hlast   = '0;
    hready  = 1'b1;

    // Reset, then both request single beats: strict alternation from master 0.
    cycle(1'b0, 2'b11, 2'b11, 1'b1);
    cycle(1'b0, 2'b11, 2'b11, 1'b1);
    check("rst_sel", sel, 2'b00);
    cycle(1'b1, 2'b11, 2'b11, 1'b1);
    check("first_grant", sel, 2'b01);
    cycle(1'b1, 2'b11, 2'b11, 1'b1);
    check("alt_1", sel, 2'b10);
    cycle(1'b1, 2'b11, 2'b11, 1'b1);
    check("alt_0", sel, 2'b01);
    cycle(1'b1, 2'b11, 2'b11, 1'b1);
    check("alt_1b", sel, 2'b10);

    // Burst hold by master 1, then handover after its final beat.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'b11, 2'b01, 1'b1);
      check("burst_hold", sel, 2'b10);
    end
    cycle(1'b1, 2'b11, 2'b11, 1'b1);
    check("burst_handover", sel, 2'b01);

    // Wait states freeze sel and sel_dp.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 2'b11, 2'b11, 1'b0);
      check("wait_sel", sel, 2'b01);
      check("wait_dp", sel_dp, 2'b10);
    end
    cycle(1'b1, 2'b11, 2'b11, 1'b1);
    check("wait_handover", sel, 2'b10);

    // Release to idle and regrant.
    cycle(1'b1, 2'b01, 2'b01, 1'b1);
    check("to_m0", sel, 2'b01);
    cycle(1'b1, 2'b00, 2'b00, 1'b1);
    check("idle_sel", sel, 2'b00);
    check("idle_busy", busy, 1'b0);
    check("idle_dp", sel_dp, 2'b00);
    cycle(1'b1, 2'b01, 2'b00, 1'b1);
    check("regrant", sel, 2'b01);

    // Reset in the middle of a master-1 burst.
    cycle(1'b1, 2'b10, 2'b00, 1'b1);
    check("m1_own", sel, 2'b10);
    cycle(1'b1, 2'b10, 2'b00, 1'b1);
    cycle(1'b0, 2'b11, 2'b00, 1'b1);
    check("midrst_sel", sel, 2'b00);
    check("midrst_dp", sel_dp, 2'b00);
    cycle(1'b1, 2'b11, 2'b11, 1'b1);
    check("ptr_reset", sel, 2'b01);

`ifdef AHB_ARB_TIMEOUT_EN
    // Forced handover after MH accepted beats when master 1 waits.
    for (int i = 0; i < MH - 1; i++) begin
      cycle(1'b1, 2'b11, 2'b00, 1'b1);
      check("to_hold", sel, 2'b01);
    end
    cycle(1'b1, 2'b11, 2'b00, 1'b1);
    check("to_force", sel, 2'b10);
    cycle(1'b1, 2'b01, 2'b00, 1'b1);
    for (int i = 0; i < 2 * MH; i++) begin
      cycle(1'b1, 2'b01, 2'b00, 1'b1);
      check("to_sole", sel, 2'b01);
    end
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(1'b1 && ($urandom_range(0, 99) != 0),
            CN'($urandom_range(0, (1 << CN) - 1)),
            CN'($urandom_range(0, (1 << CN) - 1)) & CN'($urandom_range(0, (1 << CN) - 1)),
            ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_arbiter_slave_2.md
Name: ahb_arbiter_slave_2

Overview:
- Per-slave arbiter for slave 2 in the generated AHB interconnect.
- Takes decoded requests from CHANNEL_NUM masters and grants address-phase ownership round-robin.
- Drives the one-hot sel that steers the slave-2 payload mux.
- Also produces a data-phase owner vector, delayed by one accepted transfer, for the response return path.

Parameters:
- CHANNEL_NUM, 2, number of masters that can address slave 2.
- MAX_HOLD, 16, accepted beats before forced handover. Used only with AHB_ARB_TIMEOUT_EN. Legal range 2..255.

Ports:
- HCLK  input  1  system clock; all logic on rising edge.
- HRESETn  input  1  synchronous active-low reset.
- hreq  input  CHANNEL_NUM  per-master request, already address-decoded to slave 2.
- hlast  input  CHANNEL_NUM  per-master flag: the current address beat is the final beat of the transfer (single or last burst beat).
- hready  input  1  slave-2 HREADY; an address beat is accepted when the owner's hreq=1 and hready=1.
- sel  output  CHANNEL_NUM  registered one-hot address-phase grant; all zeros when no owner. Drives the payload mux sel.
- sel_dp  output  CHANNEL_NUM  registered one-hot data-phase owner.
- busy  output  1  high while an owner is granted.

Behaviour:
- Interface: one clock, HCLK. Reset HRESETn is synchronous and active-low.
- Reset (HRESETn=0 at a rising edge):
  - sel=0, sel_dp=0, busy=0, state=IDLE.
  - Round-robin pointer last=CHANNEL_NUM-1, so master 0 has top priority after reset.
  - Hold counter=0.
  - Reset mid-burst aborts ownership immediately. No partial-state retention.
- States:
  - IDLE: no owner.
  - OWN: sel holds one-hot owner o.
- Arbitration order: search from last+1 upward, wrapping modulo CHANNEL_NUM. The first set hreq bit wins. The winner becomes last.
- IDLE transitions:
  - Any hreq set at edge n: sel=one-hot(winner) and busy=1 from n+1; go to OWN. Request-to-grant latency is 1 cycle.
  - Otherwise stay in IDLE.
- OWN, release condition: hready=1 and (hreq[o]=0, or hreq[o]=1 with hlast[o]=1).
  - On release, re-arbitrate among current hreq from last+1. Since last=o, o is lowest priority; it can regrant itself only if no other master requests.
  - Winner found: sel switches to the new one-hot at the next edge with no idle gap (back-to-back handover).
  - No requester: sel=0, busy=0, go to IDLE.
- OWN with hready=0: sel frozen regardless of hreq/hlast changes. Wait states never cause handover.
- sel_dp:
  - On every edge with hready=1: sel_dp <= sel gated by hreq, i.e. sel if the owner's hreq=1, else 0.
  - hready=0: sel_dp holds.
- Invariants:
  - sel and sel_dp are always zero or one-hot; never multi-hot.
  - Simultaneous requests are resolved only by the pointer.
  - Requests arriving mid-burst are ignored until release.
- hlast with hreq=0 is don't-care.

Optional Feature:
- Macro: AHB_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit hold counter increments on each accepted beat by the owner.
  - It clears on grant change and on entry to IDLE.
  - When counter=MAX_HOLD-1, another master requests, and the beat is accepted, release is forced even if hlast[o]=0; the normal winner search applies.
  - The interrupted master re-requests and competes normally.
  - Counter saturates at MAX_HOLD-1 while no other request exists; no forced release in that case.
- Not defined: no counter logic. Release occurs only per the release condition in Behaviour; ownership is unbounded.

Test Plan:
- Reset/first grant: HRESETn=0 for 2 cycles, then hreq=2'b11, hready=1, hlast=2'b11 -> sel=2'b01 one cycle after request; next edge sel=2'b10; then alternates 01/10 every cycle.
- Burst hold: master 1 granted, hlast[1]=0 for 3 beats, hreq[0]=1 throughout -> sel stays 2'b10 for 4 beats; switches to 2'b01 the edge after the beat with hlast[1]=1.
- Wait states: owner 0 with hlast=1, hready=0 for 5 cycles, hreq=2'b11 -> sel=2'b01 and sel_dp unchanged for all 5; handover to 2'b10 on the first edge after hready=1.
- Release to idle: sole owner 0 drops hreq with hready=1 -> next edge sel=0, busy=0, sel_dp=0; later hreq=2'b01 -> sel=2'b01 after 1 cycle.
- Reset mid-burst: owner 1 at beat 2 of 4, HRESETn=0 one cycle -> sel=0, sel_dp=0; with hreq=2'b11 after reset, master 0 wins (pointer reset).
- AHB_ARB_TIMEOUT_EN, MAX_HOLD=4: owner 0 holds hlast=0 with hreq[1]=1 -> after 4 accepted beats sel=2'b10. With hreq[1]=0, master 0 keeps ownership beyond 4 beats.
